// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types, constants and helpers for ram_sp_init
package ram_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int RD_LAT_1 = 1;
    localparam int RD_LAT_2 = 2;

    function automatic int lane_width(input int dw, input int lanes);
        return dw / lanes;
    endfunction

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - lane-enabled storage array with one registered read port
module ram_array
    import ram_pkg::*;
#(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int LANES = 2
) (
    input  logic             clk_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic [LANES-1:0] we_i,
    input  logic             re_i,
    output logic [DW-1:0]    rdata_o
);

    localparam int LW = lane_width(DW, LANES);

    logic [DW-1:0] mem_q [1<<AW];
    logic [DW-1:0] rdata_q;

    // Per-lane writes and registered read; no reset on storage or read register
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LANES; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][i*LW +: LW] <= wdata_i[i*LW +: LW];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_sp_init.sv
// rtl/ram_sp_init.sv - single-port RAM with clear sweep and selectable read latency (optional RAM_MASK_EN)
module ram_sp_init
    import ram_pkg::*;
#(
    parameter int            AW       = 4,
    parameter int            DW       = 8,
    parameter int            LANES    = 2,
    parameter int            RD_LAT   = 1,
    parameter logic [DW-1:0] INIT_VAL = '0,
    parameter logic [DW-1:0] MASK     = '1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [AW-1:0]    A,
    input  logic [DW-1:0]    D,
    input  logic             EN,
    input  logic             WR,
    input  logic [LANES-1:0] BE,
    input  logic             CLR,
    output logic [DW-1:0]    Q,
    output logic             QV,
    output logic             BUSY
);

`ifdef RAM_MASK_EN
    localparam logic [DW-1:0] EFF_MASK = MASK;
`else
    // Mask disabled: every bit passes
    localparam logic [DW-1:0] EFF_MASK = MASK | ~MASK;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic             sweep_we;
    logic             acc_ok;
    logic             rd_en;
    logic             wr_en;
    logic [AW-1:0]    arr_addr;
    logic [DW-1:0]    arr_wdata;
    logic [LANES-1:0] arr_we;
    logic [DW-1:0]    arr_rdata;
    logic [DW-1:0]    rd_data;
    logic             v1_q;

    // Memory is left alone while RST is held; accesses only happen in RUN
    assign sweep_we  = (state_q == SWEEP) && !RST;
    assign acc_ok    = (state_q == RUN) && EN && !RST;
    assign rd_en     = acc_ok && !WR;
    assign wr_en     = acc_ok && WR;
    assign arr_addr  = sweep_we ? cnt_q : A;
    assign arr_wdata = sweep_we ? (INIT_VAL & EFF_MASK) : (D & EFF_MASK);
    assign arr_we    = sweep_we ? {LANES{1'b1}} : (wr_en ? BE : '0);
    assign BUSY      = (state_q == SWEEP);

    ram_array #(
        .AW    (AW),
        .DW    (DW),
        .LANES (LANES)
    ) u_array (
        .clk_i   (CLK),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .we_i    (arr_we),
        .re_i    (rd_en),
        .rdata_o (arr_rdata)
    );

    // Next state: sweep walks every address once; CLR is only honoured in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (CLR) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            default: state_d = SWEEP;
        endcase
    end

    // State and sweep counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // First read-valid stage, tracks the array read register
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= rd_en;
        end
    end

    assign rd_data = arr_rdata & EFF_MASK;

    if (RD_LAT == RD_LAT_2) begin : g_lat2
        logic          v2_q;
        logic [DW-1:0] q2_q;

        // Extra output stage; in-flight reads drain regardless of sweep state
        always_ff @(posedge CLK) begin
            if (RST) begin
                v2_q <= 1'b0;
                q2_q <= '0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) begin
                    q2_q <= rd_data;
                end
            end
        end

        assign Q  = q2_q;
        assign QV = v2_q;
    end else begin : g_lat1
        logic have_q;

        // Array read register has no reset, so Q reads as zero until a read lands
        always_ff @(posedge CLK) begin
            if (RST) begin
                have_q <= 1'b0;
            end else if (rd_en) begin
                have_q <= 1'b1;
            end
        end

        assign Q  = have_q ? rd_data : '0;
        assign QV = v1_q;
    end

endmodule

// File: tb/tb_ram_sp_init.sv
// tb/tb_ram_sp_init.sv - directed self-checking bench for ram_sp_init
module tb_ram_sp_init;

`ifdef RAM_MASK_EN
    localparam logic [7:0] M = 8'h0F;
`else
    localparam logic [7:0] M = 8'hFF;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] A;
    logic [7:0] D;
    logic       EN;
    logic       WR;
    logic [1:0] BE;
    logic       CLR;
    logic [7:0] Q1, Q2;
    logic       QV1, QV2;
    logic       BUSY1, BUSY2;

    int passed = 0;
    int total  = 0;
    int n;

    always #5 CLK = ~CLK;

    ram_sp_init #(.AW(4), .DW(8), .LANES(2), .RD_LAT(1), .INIT_VAL(8'h00), .MASK(8'h0F)) dut1 (
        .CLK(CLK), .RST(RST), .A(A), .D(D), .EN(EN), .WR(WR), .BE(BE), .CLR(CLR),
        .Q(Q1), .QV(QV1), .BUSY(BUSY1)
    );

    ram_sp_init #(.AW(4), .DW(8), .LANES(2), .RD_LAT(2), .INIT_VAL(8'h00), .MASK(8'h0F)) dut2 (
        .CLK(CLK), .RST(RST), .A(A), .D(D), .EN(EN), .WR(WR), .BE(BE), .CLR(CLR),
        .Q(Q2), .QV(QV2), .BUSY(BUSY2)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [1:0] be);
        A = a; D = d; BE = be; EN = 1'b1; WR = 1'b1;
        step();
        EN = 1'b0; WR = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        A = a; EN = 1'b1; WR = 1'b0;
        step();
        EN = 1'b0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (BUSY1 && cnt < 40) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        RST = 1'b1; A = '0; D = '0; EN = 1'b0; WR = 1'b0; BE = 2'b11; CLR = 1'b0;

        // 1. reset state, initial sweep length, all words cleared
        repeat (3) step();
        chk("rst_busy", {7'd0, BUSY1}, 8'd1);
        chk("rst_qv", {7'd0, QV1}, 8'd0);
        chk("rst_q", Q1, 8'h00);
        chk("rst_q2", Q2, 8'h00);
        RST = 1'b0;
        count_busy(n);
        chk("init_sweep_len", n[7:0], 8'd16);
        for (int a = 0; a < 16; a++) begin
            A = a[3:0]; EN = 1'b1; WR = 1'b0;
            step();
            chk("init_rd_qv", {7'd0, QV1}, 8'd1);
            chk("init_rd_q", Q1, 8'h00);
        end
        EN = 1'b0;
        step();
        chk("idle_qv", {7'd0, QV1}, 8'd0);

        // 2. lane write enables
        wr(4'd3, 8'hA5, 2'b11);
        wr(4'd3, 8'h3C, 2'b01);
        rd(4'd3);
        chk("lane_qv", {7'd0, QV1}, 8'd1);
        chk("lane_q", Q1, 8'hAC & M);
        step();
        chk("lane_qv_once", {7'd0, QV1}, 8'd0);
        chk("q_hold", Q1, 8'hAC & M);
        wr(4'd4, 8'h55, 2'b11);
        wr(4'd4, 8'hAA, 2'b00);
        rd(4'd4);
        chk("be0_noop", Q1, 8'h55 & M);

        // 3. RD_LAT=2 pipelined reads
        wr(4'd0, 8'h11, 2'b11);
        wr(4'd1, 8'h22, 2'b11);
        wr(4'd2, 8'h33, 2'b11);
        A = 4'd0; EN = 1'b1; WR = 1'b0;
        step();
        chk("lat2_qv_t1", {7'd0, QV2}, 8'd0);
        chk("lat1_q_t1", Q1, 8'h11 & M);
        A = 4'd1;
        step();
        chk("lat2_qv_t2", {7'd0, QV2}, 8'd1);
        chk("lat2_q_t2", Q2, 8'h11 & M);
        A = 4'd2;
        step();
        chk("lat2_qv_t3", {7'd0, QV2}, 8'd1);
        chk("lat2_q_t3", Q2, 8'h22 & M);
        EN = 1'b0;
        step();
        chk("lat2_qv_t4", {7'd0, QV2}, 8'd1);
        chk("lat2_q_t4", Q2, 8'h33 & M);
        step();
        chk("lat2_qv_t5", {7'd0, QV2}, 8'd0);

        // 4. CLR with a same-cycle read; writes during sweep dropped; CLR mid-sweep ignored
        wr(4'd5, 8'hFF, 2'b11);
        A = 4'd5; EN = 1'b1; WR = 1'b0; CLR = 1'b1;
        step();
        CLR = 1'b0;
        chk("clr_rd_qv", {7'd0, QV1}, 8'd1);
        chk("clr_rd_q", Q1, 8'hFF & M);
        chk("clr_busy", {7'd0, BUSY1}, 8'd1);
        A = 4'd5; D = 8'hAA; BE = 2'b11; EN = 1'b1; WR = 1'b1;
        n = 0;
        while (BUSY1 && n < 40) begin
            CLR = (n == 5);
            step();
            n++;
            if (n == 3) chk("busy_qv", {7'd0, QV1}, 8'd0);
        end
        EN = 1'b0; WR = 1'b0; CLR = 1'b0;
        chk("clr_sweep_len", n[7:0], 8'd16);
        rd(4'd5);
        chk("after_clr_q", Q1, 8'h00);

        // 5. reset in the middle of a sweep restarts it
        wr(4'd7, 8'h5A, 2'b11);
        rd(4'd7);
        chk("pre_rst_q", Q1, 8'h5A & M);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        repeat (7) step();
        RST = 1'b1;
        step();
        chk("midrst_q", Q1, 8'h00);
        chk("midrst_qv", {7'd0, QV1}, 8'd0);
        chk("midrst_busy", {7'd0, BUSY1}, 8'd1);
        RST = 1'b0;
        count_busy(n);
        chk("midrst_sweep_len", n[7:0], 8'd16);
        rd(4'd7);
        chk("midrst_cleared", Q1, 8'h00);

        // 6. data mask
        wr(4'd9, 8'hF7, 2'b11);
        rd(4'd9);
        chk("mask_q", Q1, 8'hF7 & M);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
